// File: rtl/player_arb_pkg.sv
// Shared constants and state encoding for the music-player arbiter.
// Requester indices double as priorities: a lower index wins.
package player_arb_pkg;

  localparam int unsigned MSC_N = 8;

  localparam int unsigned REQ_ALARM = 0;
  localparam int unsigned REQ_CHIME = 1;
  localparam int unsigned REQ_TIMER = 2;
  localparam int unsigned REQ_KEY   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_PLAY,
    ST_ABORT,
    ST_GAP
  } state_e;

endpackage

// File: rtl/player_arb_prio_enc.sv
// Lowest-index-wins priority encoder over the pending request vector.
module player_arb_prio_enc #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] pend,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Walk down so the lowest set index is the last one written.
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_arb.sv
// Fixed-priority arbiter for the shared music player: latches requests, launches the winner,
// preempts for higher priority, ramps alarm volume and enforces a hard play timeout.
module player_arb #(
  parameter int unsigned      N_REQ      = 4,
  parameter int unsigned      MSC_N      = player_arb_pkg::MSC_N,
  parameter int unsigned      TRK_W      = 3,
  parameter int unsigned      GAP_MS     = 20,
  parameter int unsigned      TIMEOUT_MS = 60000,
  parameter int unsigned      RAMP_MS    = 500,
  parameter int unsigned      VOL_STEP   = 64,
  parameter logic [N_REQ-1:0] RAMP_EN    = N_REQ'(1)
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*TRK_W-1:0] req_track,
  input  logic [N_REQ*10-1:0]    req_vol,
  input  logic                   cancel,
  input  logic                   play_done,
  input  logic                   ms_tick,
  output logic [MSC_N-1:0]       start,
  output logic [9:0]             volume,
  output logic                   abort,
  output logic                   busy,
  output logic [1:0]             grant_id
);
  import player_arb_pkg::*;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d, pend_eff, req_ok;
  logic [TRK_W-1:0] trk_q [N_REQ];
  logic [9:0]       tgt_q [N_REQ];
  logic [1:0]       owner_q, win_idx;
  logic             win_valid, clear_all, cancel_q;
  logic             preempt, timeout_hit, gap_done, ramp_step, ramp_on;
  logic [15:0]      ms_cnt_q, ramp_cnt_q;
  logic [9:0]       play_vol_q, max_vol_q, launch_vol, ramp_vol;
  logic [10:0]      ramp_sum;

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_ok[i] = req[i] && (32'(req_track[i*TRK_W +: TRK_W]) < MSC_N);
    end
  end

  assign clear_all = cancel || (state_q == ST_ABORT && cancel_q);
  assign pend_eff  = (pend_q | req_ok) & ~{N_REQ{clear_all}};

  player_arb_prio_enc #(
    .N_REQ(N_REQ),
    .IDX_W(2)
  ) u_prio_enc (
    .pend (pend_eff),
    .idx  (win_idx),
    .valid(win_valid)
  );

  always_comb begin
    pend_d = pend_eff;
    if (state_q == ST_IDLE && win_valid) pend_d[win_idx] = 1'b0;
  end

  assign preempt     = win_valid && (win_idx < owner_q);
  assign timeout_hit = ms_tick && (32'(ms_cnt_q) >= TIMEOUT_MS - 1);
  assign gap_done    = ms_tick && (32'(ms_cnt_q) >= GAP_MS - 1);
  assign ramp_step   = ms_tick && (32'(ramp_cnt_q) >= RAMP_MS - 1);
  assign ramp_on     = RAMP_EN[owner_q];

  always_comb begin
    launch_vol = tgt_q[owner_q];
    if (ramp_on && (32'(tgt_q[owner_q]) > VOL_STEP)) launch_vol = 10'(VOL_STEP);
  end

  // 11-bit sum so a step past full scale saturates instead of wrapping.
  assign ramp_sum = {1'b0, play_vol_q} + 11'(VOL_STEP);
  assign ramp_vol = (ramp_sum > {1'b0, max_vol_q}) ? max_vol_q : ramp_sum[9:0];

  always_ff @(posedge sysclk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (win_valid) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = cancel ? ST_ABORT : ST_PLAY;
      ST_PLAY: begin
        if (cancel || preempt || timeout_hit) state_d = ST_ABORT;
        else if (play_done)                   state_d = ST_GAP;
      end
      ST_ABORT:  state_d = ST_GAP;
      ST_GAP:    if (gap_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int j = 0; j < int'(MSC_N); j++) begin
      start[j] = (state_q == ST_LAUNCH) && (32'(trk_q[owner_q]) == 32'(j));
    end
    volume = '0;
    if (state_q == ST_LAUNCH)    volume = launch_vol;
    else if (state_q == ST_PLAY) volume = play_vol_q;
    abort    = (state_q == ST_ABORT);
    busy     = (state_q != ST_IDLE);
    grant_id = owner_q;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      pend_q     <= '0;
      owner_q    <= '0;
      cancel_q   <= 1'b0;
      ms_cnt_q   <= '0;
      ramp_cnt_q <= '0;
      play_vol_q <= '0;
      max_vol_q  <= '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        trk_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (req_ok[i]) begin
          trk_q[i] <= req_track[i*TRK_W +: TRK_W];
          tgt_q[i] <= req_vol[i*10 +: 10];
        end
      end
      if (state_q == ST_IDLE && win_valid) owner_q <= win_idx;
      if (state_d == ST_ABORT && state_q != ST_ABORT) cancel_q <= cancel;
      // One ms counter serves both the play timeout and the gap; it restarts on every state change.
      if (state_d != state_q)               ms_cnt_q <= '0;
      else if (ms_tick && ms_cnt_q != '1)   ms_cnt_q <= ms_cnt_q + 16'd1;
      if (state_q == ST_LAUNCH) begin
        ramp_cnt_q <= '0;
        play_vol_q <= launch_vol;
        max_vol_q  <= tgt_q[owner_q];
      end else if (state_q == ST_PLAY && ms_tick) begin
        ramp_cnt_q <= ramp_step ? '0 : ramp_cnt_q + 16'd1;
        if (ramp_on && ramp_step) play_vol_q <= ramp_vol;
      end
    end
  end

endmodule
